// File: rtl/uart_receiver.sv
// 8N1 UART receiver: 16x oversampling via external baud_tick, mid-bit sampling,
// single-entry holding register with framing and sticky overrun flags.
module uart_receiver (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rxd,
  input  logic       baud_tick,
  output logic       rx_start,
  input  logic       rx_read,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       framing_err,
  output logic       overrun_err,
  output logic       rx_busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_e;

  state_e     state_q, state_d;
  logic [3:0] tick_cnt_q, tick_cnt_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       rx_valid_q, rx_valid_d;
  logic       framing_err_q, framing_err_d;
  logic       overrun_err_q, overrun_err_d;
  logic       rx_start_q, rx_start_d;

  logic sync1_q, sync2_q, prev_q;
  logic rxd_s;
  logic fall;
  logic load;
  logic pop;

  // NOTE: these reset to 1 (idle line level) so releasing reset with rxd high
  // cannot look like a falling edge and fire a spurious start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
    end else begin
      sync1_q <= rxd;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign rxd_s = sync2_q;
  assign fall  = prev_q & ~sync2_q;
  assign pop   = rx_read & rx_valid_q;

  // NOTE: sequential state uses non-blocking assignments only; all next-state
  // decisions live in the always_comb below, where every _d gets a default
  // first so no latch can be inferred.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      tick_cnt_q    <= 4'd0;
      bit_cnt_q     <= 3'd0;
      shift_q       <= 8'h00;
      rx_data_q     <= 8'h00;
      rx_valid_q    <= 1'b0;
      framing_err_q <= 1'b0;
      overrun_err_q <= 1'b0;
      rx_start_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      tick_cnt_q    <= tick_cnt_d;
      bit_cnt_q     <= bit_cnt_d;
      shift_q       <= shift_d;
      rx_data_q     <= rx_data_d;
      rx_valid_q    <= rx_valid_d;
      framing_err_q <= framing_err_d;
      overrun_err_q <= overrun_err_d;
      rx_start_q    <= rx_start_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    rx_start_d = 1'b0;
    load       = 1'b0;

    case (state_q)
      IDLE: begin
        if (fall) begin
          state_d    = START;
          tick_cnt_d = 4'd0;
          bit_cnt_d  = 3'd0;
          rx_start_d = 1'b1;
        end
      end
      START: begin
        // Half a bit in: a line back high means a glitch, not a start bit.
        if (baud_tick) begin
          if (tick_cnt_q == 4'd7) begin
            tick_cnt_d = 4'd0;
            state_d    = rxd_s ? IDLE : DATA;
          end else begin
            tick_cnt_d = tick_cnt_q + 4'd1;
          end
        end
      end
      DATA: begin
        if (baud_tick) begin
          tick_cnt_d = tick_cnt_q + 4'd1;
          if (tick_cnt_q == 4'd15) begin
            shift_d   = {rxd_s, shift_q[7:1]};
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              state_d    = STOP;
              tick_cnt_d = 4'd0;
            end
          end
        end
      end
      STOP: begin
        if (baud_tick) begin
          tick_cnt_d = tick_cnt_q + 4'd1;
          if (tick_cnt_q == 4'd15) begin
            load    = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Holding register: a load wins over a pop for rx_valid; a pop in the same
  // cycle as a load means the old byte was consumed, so no overrun.
  always_comb begin
    rx_data_d     = rx_data_q;
    rx_valid_d    = rx_valid_q;
    framing_err_d = framing_err_q;
    overrun_err_d = overrun_err_q;

    if (load) begin
      rx_data_d     = shift_q;
      rx_valid_d    = 1'b1;
      framing_err_d = ~rxd_s;
    end else if (pop) begin
      rx_valid_d = 1'b0;
    end

    if (load && rx_valid_q && !rx_read) begin
      overrun_err_d = 1'b1;
    end else if (pop) begin
      overrun_err_d = 1'b0;
    end
  end

  assign rx_start    = rx_start_q;
  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign framing_err = framing_err_q;
  assign overrun_err = overrun_err_q;
  assign rx_busy     = (state_q != IDLE);

endmodule

// File: tb/tb_uart_receiver.sv
// Self-checking bench for uart_receiver: directed vector table, multi-cycle
// corner sequences, and random frames against a frame-level holding model.
`timescale 1ns/1ps
module tb_uart_receiver;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rxd;
  logic       baud_tick;
  logic       rx_start;
  logic       rx_read;
  logic       rx_read_man;
  logic       rx_read_auto;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       framing_err;
  logic       overrun_err;
  logic       rx_busy;

  assign rx_read = rx_read_man | rx_read_auto;

  uart_receiver dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rxd         (rxd),
    .baud_tick   (baud_tick),
    .rx_start    (rx_start),
    .rx_read     (rx_read),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .framing_err (framing_err),
    .overrun_err (overrun_err),
    .rx_busy     (rx_busy)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Tick generator and monitors, all updated on the falling edge.
  int tick_per    = 16;
  bit tick_en     = 1'b0;
  int div         = 0;
  int start_cnt   = 0;
  int busy_cnt    = 0;
  int frame_ticks = 0;
  bit in_frame    = 1'b0;
  bit arm_read    = 1'b0;
  int auto_reads  = 0;

  // Ticks from rx_start to the stop-bit sample: 8 + 8*16 + 16.
  localparam int LOAD_TICK = 152;

  initial begin
    baud_tick    = 1'b0;
    rx_read_auto = 1'b0;
    forever begin
      @(negedge clk);
      rx_read_auto = 1'b0;
      if (tick_en) begin
        div       = (div >= tick_per - 1) ? 0 : div + 1;
        baud_tick = (div == 0);
      end else begin
        div       = 0;
        baud_tick = 1'b0;
      end
      if (rx_start === 1'b1) begin
        start_cnt++;
        frame_ticks = 0;
        in_frame    = 1'b1;
      end
      if (rx_busy === 1'b1) busy_cnt++;
      if (in_frame && baud_tick) begin
        frame_ticks++;
        if (frame_ticks == LOAD_TICK) begin
          in_frame = 1'b0;
          if (arm_read) begin
            rx_read_auto = 1'b1;
            arm_read     = 1'b0;
            auto_reads++;
          end
        end
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Frame-level reference model of the holding register.
  logic [7:0] m_data;
  logic       m_valid, m_ferr, m_ovr;

  function automatic void model_reset();
    m_data  = 8'h00;
    m_valid = 1'b0;
    m_ferr  = 1'b0;
    m_ovr   = 1'b0;
  endfunction

  function automatic void model_frame(input logic [7:0] b, input logic stop_bit);
    if (m_valid) m_ovr = 1'b1;
    m_valid = 1'b1;
    m_data  = b;
    m_ferr  = !stop_bit;
  endfunction

  function automatic void model_read();
    if (m_valid) begin
      m_valid = 1'b0;
      m_ovr   = 1'b0;
    end
  endfunction

  function automatic int bit_time();
    return 16 * tick_per;
  endfunction

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    rxd = 1'b0;
    wait_clk(bit_time());
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      wait_clk(bit_time());
    end
    rxd = stop_bit;
    wait_clk(bit_time());
    rxd = 1'b1;
    wait_clk(bit_time());
  endtask

  task automatic do_read();
    rx_read_man = 1'b1;
    @(negedge clk);
    rx_read_man = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    wait_clk(3);
    rst_n = 1'b1;
    wait_clk(2);
    model_reset();
  endtask

  task automatic check_model(input string tag);
    check({tag, " rx_data"},     {24'h0, rx_data}, {24'h0, m_data});
    check({tag, " rx_valid"},    {31'h0, rx_valid}, {31'h0, m_valid});
    check({tag, " framing_err"}, {31'h0, framing_err}, {31'h0, m_ferr});
    check({tag, " overrun_err"}, {31'h0, overrun_err}, {31'h0, m_ovr});
  endtask

  typedef struct {
    logic [7:0] d;
    logic       stop;
    logic       rd;
    logic [7:0] e_data;
    logic       e_valid;
    logic       e_ferr;
    logic       e_ovr;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int s0;
    logic [7:0] b;
    logic       sb;
    logic [7:0] partial;

    vecs[0] = '{d: 8'hA5, stop: 1'b1, rd: 1'b1, e_data: 8'hA5, e_valid: 1'b1, e_ferr: 1'b0, e_ovr: 1'b0};
    vecs[1] = '{d: 8'h3C, stop: 1'b0, rd: 1'b1, e_data: 8'h3C, e_valid: 1'b1, e_ferr: 1'b1, e_ovr: 1'b0};
    vecs[2] = '{d: 8'h11, stop: 1'b1, rd: 1'b0, e_data: 8'h11, e_valid: 1'b1, e_ferr: 1'b0, e_ovr: 1'b0};
    vecs[3] = '{d: 8'h22, stop: 1'b1, rd: 1'b1, e_data: 8'h22, e_valid: 1'b1, e_ferr: 1'b0, e_ovr: 1'b1};
    vecs[4] = '{d: 8'h00, stop: 1'b1, rd: 1'b0, e_data: 8'h00, e_valid: 1'b1, e_ferr: 1'b0, e_ovr: 1'b0};
    vecs[5] = '{d: 8'hFF, stop: 1'b0, rd: 1'b1, e_data: 8'hFF, e_valid: 1'b1, e_ferr: 1'b1, e_ovr: 1'b1};

    rst_n       = 1'b0;
    rxd         = 1'b1;
    rx_read_man = 1'b0;
    tick_per    = 16;
    tick_en     = 1'b1;
    wait_clk(4);
    rst_n = 1'b1;

    // Idle line with ticks running: nothing may happen.
    wait_clk(1000);
    check("idle rx_start count", start_cnt, 0);
    check("idle busy cycles", busy_cnt, 0);
    check("idle rx_busy", {31'h0, rx_busy}, 32'h0);
    check("idle rx_data", {24'h0, rx_data}, 32'h0);
    check("idle rx_valid", {31'h0, rx_valid}, 32'h0);
    check("idle framing_err", {31'h0, framing_err}, 32'h0);
    check("idle overrun_err", {31'h0, overrun_err}, 32'h0);

    tick_per = 4;
    wait_clk(bit_time());

    for (int i = 0; i < 6; i++) begin
      s0 = start_cnt;
      send_frame(vecs[i].d, vecs[i].stop);
      check($sformatf("vec%0d starts", i), start_cnt - s0, 1);
      check($sformatf("vec%0d rx_data", i), {24'h0, rx_data}, {24'h0, vecs[i].e_data});
      check($sformatf("vec%0d rx_valid", i), {31'h0, rx_valid}, {31'h0, vecs[i].e_valid});
      check($sformatf("vec%0d framing_err", i), {31'h0, framing_err}, {31'h0, vecs[i].e_ferr});
      check($sformatf("vec%0d overrun_err", i), {31'h0, overrun_err}, {31'h0, vecs[i].e_ovr});
      check($sformatf("vec%0d rx_busy", i), {31'h0, rx_busy}, 32'h0);
      if (vecs[i].rd) begin
        do_read();
        check($sformatf("vec%0d read rx_valid", i), {31'h0, rx_valid}, 32'h0);
        check($sformatf("vec%0d read overrun_err", i), {31'h0, overrun_err}, 32'h0);
        check($sformatf("vec%0d read framing_err", i), {31'h0, framing_err}, {31'h0, vecs[i].e_ferr});
      end
    end

    // Read while empty has no effect.
    do_read();
    check("empty read rx_valid", {31'h0, rx_valid}, 32'h0);
    check("empty read rx_data", {24'h0, rx_data}, 32'hFF);

    // False start: low for 3 ticks, then high before the mid-bit sample.
    s0 = start_cnt;
    rxd = 1'b0;
    wait_clk(3 * tick_per);
    check("false start rx_busy early", {31'h0, rx_busy}, 32'h1);
    rxd = 1'b1;
    wait_clk(10 * tick_per);
    check("false start starts", start_cnt - s0, 1);
    check("false start rx_busy late", {31'h0, rx_busy}, 32'h0);
    check("false start rx_valid", {31'h0, rx_valid}, 32'h0);
    check("false start rx_data", {24'h0, rx_data}, 32'hFF);
    check("false start framing_err", {31'h0, framing_err}, 32'h1);
    wait_clk(bit_time());

    // Load and pop in the same cycle: new byte kept, no overrun.
    send_frame(8'h77, 1'b1);
    check("same-cycle first rx_valid", {31'h0, rx_valid}, 32'h1);
    s0 = auto_reads;
    arm_read = 1'b1;
    send_frame(8'h88, 1'b1);
    check("same-cycle pop issued", auto_reads - s0, 1);
    check("same-cycle rx_data", {24'h0, rx_data}, 32'h88);
    check("same-cycle rx_valid", {31'h0, rx_valid}, 32'h1);
    check("same-cycle overrun_err", {31'h0, overrun_err}, 32'h0);
    arm_read = 1'b0;

    // Reset in the middle of the 4th data bit of a frame, then a clean frame.
    partial = 8'hC3;
    rxd = 1'b0;
    wait_clk(bit_time());
    for (int i = 0; i < 3; i++) begin
      rxd = partial[i];
      wait_clk(bit_time());
    end
    rxd = partial[3];
    wait_clk(bit_time() / 2);
    check("mid-frame rx_busy", {31'h0, rx_busy}, 32'h1);
    rst_n = 1'b0;
    wait_clk(2);
    check("in-reset rx_busy", {31'h0, rx_busy}, 32'h0);
    rxd = 1'b1;
    wait_clk(2);
    rst_n = 1'b1;
    s0 = start_cnt;
    wait_clk(bit_time());
    check("post-reset starts", start_cnt - s0, 0);
    check("post-reset rx_busy", {31'h0, rx_busy}, 32'h0);
    check("post-reset rx_data", {24'h0, rx_data}, 32'h0);
    check("post-reset rx_valid", {31'h0, rx_valid}, 32'h0);
    check("post-reset framing_err", {31'h0, framing_err}, 32'h0);
    check("post-reset overrun_err", {31'h0, overrun_err}, 32'h0);
    send_frame(8'h5A, 1'b1);
    check("post-reset frame rx_data", {24'h0, rx_data}, 32'h5A);
    check("post-reset frame rx_valid", {31'h0, rx_valid}, 32'h1);
    check("post-reset frame framing_err", {31'h0, framing_err}, 32'h0);
    check("post-reset frame overrun_err", {31'h0, overrun_err}, 32'h0);

    // Random frames and pops against the frame-level model.
    do_reset();
    check_model("rand reset");
    for (int i = 0; i < 12; i++) begin
      if ($urandom_range(1, 0) == 1) begin
        do_read();
        model_read();
      end
      b  = 8'($urandom);
      sb = ($urandom_range(7, 0) != 0);
      s0 = start_cnt;
      send_frame(b, sb);
      model_frame(b, sb);
      check($sformatf("rand%0d starts", i), start_cnt - s0, 1);
      check_model($sformatf("rand%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
